// File: rtl/input_sync_filter.sv
// Multi-channel input conditioner for asynchronous pins: N-stage synchronizer,
// programmable stability filter, registered edge pulses and saturating rise counters.
module input_sync_filter #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FW          = 4,
    parameter int CW          = 16
) (
    input  logic              lb_clk,
    input  logic              rst,
    input  logic [NCH-1:0]    din,
    input  logic [FW-1:0]     filt_len,
    input  logic              cnt_clear,
    output logic [NCH-1:0]    dout,
    output logic [NCH-1:0]    rise,
    output logic [NCH-1:0]    fall,
    output logic [NCH*CW-1:0] edge_count
);

    localparam logic [CW-1:0] EC_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] EC_MAX = {CW{1'b1}};
    localparam logic [FW:0]   LEN_ONE = {{FW{1'b0}}, 1'b1};

    (* magic_cdc *) logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync_tail_q [SYNC_STAGES-1];
    logic [NCH-1:0] sync_s;

    logic [FW-1:0]  stab_q [NCH];
    logic [FW-1:0]  stab_d [NCH];
    logic [CW-1:0]  ec_q   [NCH];
    logic [CW-1:0]  ec_d   [NCH];
    logic [NCH-1:0] dout_q, dout_d;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] fall_q, fall_d;
    logic [FW:0]    len_s;

    assign sync_s = sync_tail_q[SYNC_STAGES-2];
    // A zero threshold is treated as one so the filter always passes a stable level.
    assign len_s  = (filt_len == {FW{1'b0}}) ? LEN_ONE : {1'b0, filt_len};

    // Synchronizer chain: plain flop-to-flop, no logic between stages.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            sync1_q <= {NCH{1'b0}};
            for (int k = 0; k < SYNC_STAGES - 1; k++) begin
                sync_tail_q[k] <= {NCH{1'b0}};
            end
        end else begin
            sync1_q        <= din;
            sync_tail_q[0] <= sync1_q;
            for (int k = 1; k < SYNC_STAGES - 1; k++) begin
                sync_tail_q[k] <= sync_tail_q[k-1];
            end
        end
    end

    // Next-state for stability filter, edge pulses and rising-edge counters.
    always_comb begin
        dout_d = dout_q;
        rise_d = {NCH{1'b0}};
        fall_d = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            stab_d[i] = stab_q[i];
            ec_d[i]   = ec_q[i];
            if (sync_s[i] == dout_q[i]) begin
                stab_d[i] = {FW{1'b0}};
            end else if (({1'b0, stab_q[i]} + LEN_ONE) >= len_s) begin
                dout_d[i] = sync_s[i];
                stab_d[i] = {FW{1'b0}};
            end else begin
                stab_d[i] = stab_q[i] + {{(FW-1){1'b0}}, 1'b1};
            end
            rise_d[i] = dout_d[i] & ~dout_q[i];
            fall_d[i] = ~dout_d[i] & dout_q[i];
            // A clear coinciding with a rise keeps that rise so no event is lost.
            if (cnt_clear) begin
                ec_d[i] = rise_d[i] ? EC_ONE : {CW{1'b0}};
            end else if (rise_d[i] && (ec_q[i] != EC_MAX)) begin
                ec_d[i] = ec_q[i] + EC_ONE;
            end else begin
                ec_d[i] = ec_q[i];
            end
        end
    end

    // Filter, pulse and counter state registers.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            dout_q <= {NCH{1'b0}};
            rise_q <= {NCH{1'b0}};
            fall_q <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                stab_q[i] <= {FW{1'b0}};
                ec_q[i]   <= {CW{1'b0}};
            end
        end else begin
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < NCH; i++) begin
                stab_q[i] <= stab_d[i];
                ec_q[i]   <= ec_d[i];
            end
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

    // Pack per-channel counters onto the flat output bus.
    always_comb begin
        edge_count = {(NCH*CW){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            edge_count[i*CW +: CW] = ec_q[i];
        end
    end

endmodule

// File: tb/tb_input_sync_filter.sv
// Bench for input_sync_filter: directed scenarios plus random stimulus against a
// run-length reference model; a CW=4 instance exercises counter saturation.
module tb_input_sync_filter;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int FW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    din;
    logic [FW-1:0]     filt_len;
    logic              cnt_clear;
    logic [NCH-1:0]    dout, rise, fall;
    logic [NCH*16-1:0] ec16;
    logic [NCH-1:0]    dout4, rise4, fall4;
    logic [NCH*4-1:0]  ec4;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NCH-1:0] m_sync [SS];
    logic [NCH-1:0] m_dout, m_rise, m_fall;
    int             m_run   [NCH];
    int             m_cnt16 [NCH];
    int             m_cnt4  [NCH];

    always #5 clk = ~clk;

    input_sync_filter #(.NCH(NCH), .SYNC_STAGES(SS), .FW(FW), .CW(16)) dut (
        .lb_clk(clk), .rst(rst), .din(din), .filt_len(filt_len), .cnt_clear(cnt_clear),
        .dout(dout), .rise(rise), .fall(fall), .edge_count(ec16)
    );

    input_sync_filter #(.NCH(NCH), .SYNC_STAGES(SS), .FW(FW), .CW(4)) dut4 (
        .lb_clk(clk), .rst(rst), .din(din), .filt_len(filt_len), .cnt_clear(cnt_clear),
        .dout(dout4), .rise(rise4), .fall(fall4), .edge_count(ec4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '0;
        m_dout = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_cnt16[i] = 0; m_cnt4[i] = 0;
        end
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic step();
        logic [NCH-1:0] s_old;
        logic [63:0]    e16;
        logic [15:0]    e4;
        int             len;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            s_old = m_sync[SS-1];
            len   = (filt_len == 0) ? 1 : int'(filt_len);
            m_rise = '0; m_fall = '0;
            for (int i = 0; i < NCH; i++) begin
                if (s_old[i] != m_dout[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= len) begin
                        m_dout[i] = s_old[i];
                        m_run[i]  = 0;
                        if (s_old[i]) m_rise[i] = 1'b1;
                        else          m_fall[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (cnt_clear) begin
                    m_cnt16[i] = m_rise[i] ? 1 : 0;
                    m_cnt4[i]  = m_rise[i] ? 1 : 0;
                end else if (m_rise[i]) begin
                    m_cnt16[i] = (m_cnt16[i] + 1 > 65535) ? 65535 : m_cnt16[i] + 1;
                    m_cnt4[i]  = (m_cnt4[i] + 1 > 15) ? 15 : m_cnt4[i] + 1;
                end
            end
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = din;
        end
        #1;
        e16 = '0; e4 = '0;
        for (int i = 0; i < NCH; i++) begin
            e16[i*16 +: 16] = 16'(m_cnt16[i]);
            e4[i*4 +: 4]    = 4'(m_cnt4[i]);
        end
        chk("dout",  dout,  m_dout);
        chk("rise",  rise,  m_rise);
        chk("fall",  fall,  m_fall);
        chk("ec16",  ec16,  e16);
        chk("dout4", dout4, m_dout);
        chk("ec4",   ec4,   e4);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1; din = '0; filt_len = 4'd3; cnt_clear = 1'b0;
        model_reset();
        steps(3);
        chk("reset_dout", dout, 4'b0000);
        chk("reset_ec",   ec16, 64'd0);
        rst = 1'b0;

        // Single clean rising step on channel 0 with L=3
        din[0] = 1'b1;
        steps(4);
        chk("t1_not_yet", dout, 4'b0000);
        step();
        chk("t1_dout", dout, 4'b0001);
        chk("t1_rise", rise, 4'b0001);
        chk("t1_ec",   ec16[15:0], 16'd1);
        step();
        chk("t1_rise_once", rise, 4'b0000);

        // Short glitch on channel 1 is rejected, a 3-cycle pulse passes
        din[1] = 1'b1; steps(2);
        din[1] = 1'b0; steps(8);
        chk("t2_glitch_ec", ec16[31:16], 16'd0);
        din[1] = 1'b1; steps(3);
        din[1] = 1'b0; steps(10);
        chk("t2_pulse_ec", ec16[31:16], 16'd1);

        // filt_len=0 behaves as 1: channel 2 tracks din with 3-edge delay
        filt_len = 4'd0;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) din[2] = ~din[2];
            step();
        end
        steps(3);
        chk("t3_ec", ec16[47:32], 16'd5);

        // 20 rising edges on channel 3: CW=4 saturates at 15
        filt_len = 4'd1;
        for (int k = 0; k < 20; k++) begin
            din[3] = 1'b1; steps(2);
            din[3] = 1'b0; steps(2);
        end
        steps(3);
        chk("t4_sat4",  ec4[15:12],  4'd15);
        chk("t4_ec16",  ec16[63:48], 16'd20);
        din[3] = 1'b1; steps(2);
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        chk("t4_clr_rise", ec4[15:12], 4'd1);
        din[3] = 1'b0; steps(4);
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        chk("t4_clr_only", ec4[15:12], 4'd0);

        // Reset mid-filter with all inputs high, then rise on all channels
        din = 4'hF; filt_len = 4'd5; steps(4);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_rst_dout", dout, 4'b0000);
            chk("t5_rst_ec",   ec16, 64'd0);
        end
        rst = 1'b0;
        steps(6);
        chk("t5_early", rise, 4'b0000);
        step();
        chk("t5_rise", rise, 4'hF);
        chk("t5_ec",   ec16, {4{16'd1}});

        // Threshold lowered while a transition is partially counted
        filt_len = 4'd8; din[0] = 1'b0;
        steps(6);
        chk("t6_hold", dout[0], 1'b1);
        filt_len = 4'd3;
        step();
        chk("t6_dout", dout[0], 1'b0);
        chk("t6_fall", fall[0], 1'b1);

        // Random stimulus against the reference model
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) din[i] = ~din[i];
            end
            if ($urandom_range(0, 49) == 0) filt_len = 4'($urandom_range(0, 4));
            cnt_clear = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; cnt_clear = 1'b0;
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
